// File: rtl/accel_conditioner.sv
// Per-axis tilt conditioner: fixed-rate sampling, zero-offset calibration, moving average,
// optional deadzone (enabled by defining ACCEL_DEADZONE_EN), sign-magnitude output.
`timescale 1ns / 1ps

module accel_conditioner #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned AVG_LOG2   = 3,
  parameter logic [7:0]  DEADZONE   = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] accel_x_in,
  input  logic [8:0] accel_y_in,
  input  logic       cal_req,
  output logic [8:0] x_out,
  output logic [8:0] y_out,
  output logic       out_valid,
  output logic       cal_busy
);

  localparam int unsigned CntW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = 11 + AVG_LOG2;

  localparam logic [CntW-1:0]    CntMax = CntW'(SAMPLE_DIV - 1);
  localparam logic signed [SumW:0] PosLim = (SumW + 1)'(255);
  localparam logic signed [SumW:0] NegLim = -PosLim;

  typedef enum logic [0:0] {StIdle, StCal} state_e;

  function automatic logic signed [10:0] sm_to_tc(input logic [8:0] sm);
    logic signed [10:0] mag;
    mag = {3'b000, sm[7:0]};
    return sm[8] ? -mag : mag;
  endfunction

  function automatic logic signed [10:0] sat11(input logic signed [SumW:0] v);
    if (v > PosLim) begin
      return 11'sd255;
    end else if (v < NegLim) begin
      return -11'sd255;
    end
    return v[10:0];
  endfunction

  function automatic logic [SumW-1:0] abs_sw(input logic signed [SumW-1:0] v);
    return v[SumW-1] ? -v : v;
  endfunction

  // Zero always maps to 9'h000, never to negative zero.
  function automatic logic [8:0] tc_to_sm(input logic signed [SumW-1:0] v);
    logic [SumW-1:0] a;
    logic [7:0]      mag;
    a   = abs_sw(v);
    mag = (a > SumW'(255)) ? 8'hFF : a[7:0];
    if (mag == 8'd0) begin
      return 9'h000;
    end
    return {v[SumW-1], mag};
  endfunction

  // Tick generator and calibrate edge detector
  logic [CntW-1:0] cnt_q;
  logic            tick;
  logic            cal_req_q;
  logic            cal_rise;

  assign tick     = (cnt_q == CntMax);
  assign cal_rise = cal_req & ~cal_req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      cal_req_q <= 1'b0;
    end else begin
      cnt_q     <= tick ? '0 : cnt_q + CntW'(1);
      cal_req_q <= cal_req;
    end
  end

  // Per-axis datapath, index 0 = X, 1 = Y
  logic [8:0]             raw      [2];
  logic signed [10:0]     tc       [2];
  logic signed [SumW:0]   diff     [2];
  logic signed [10:0]     corr_d   [2];
  logic signed [10:0]     corr_q   [2];
  logic signed [10:0]     off_d    [2];
  logic signed [10:0]     off_q    [2];
  logic signed [SumW-1:0] cal_sum_d[2];
  logic signed [SumW-1:0] cal_sum_q[2];
  logic signed [SumW-1:0] cal_tot  [2];
  logic signed [SumW-1:0] cal_sh   [2];
  logic signed [10:0]     hist_q   [2][Depth];
  logic signed [10:0]     oldest   [2];
  logic signed [SumW-1:0] sum_d    [2];
  logic signed [SumW-1:0] sum_q    [2];
  logic signed [SumW-1:0] avg      [2];
  logic [8:0]             out_d    [2];
  logic [8:0]             out_q    [2];

  logic [AVG_LOG2-1:0] ptr_q;
  logic [AVG_LOG2-1:0] cal_cnt_d, cal_cnt_q;
  state_e              state_d, state_q;
  logic                clr_hist;
  logic                v1_q, v2_q, v3_q;

  assign raw[0] = accel_x_in;
  assign raw[1] = accel_y_in;

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      tc[a]      = sm_to_tc(raw[a]);
      diff[a]    = {{(AVG_LOG2 + 1){tc[a][10]}}, tc[a]}
                 - {{(AVG_LOG2 + 1){off_q[a][10]}}, off_q[a]};
      corr_d[a]  = sat11(diff[a]);
      cal_tot[a] = cal_sum_q[a] + {{AVG_LOG2{tc[a][10]}}, tc[a]};
      cal_sh[a]  = cal_tot[a] >>> AVG_LOG2;
      oldest[a]  = hist_q[a][ptr_q];
      sum_d[a]   = sum_q[a] + {{AVG_LOG2{corr_q[a][10]}}, corr_q[a]}
                 - {{AVG_LOG2{oldest[a][10]}}, oldest[a]};
      avg[a]     = sum_q[a] >>> AVG_LOG2;
`ifdef ACCEL_DEADZONE_EN
      if (abs_sw(avg[a]) <= SumW'(DEADZONE)) begin
        avg[a] = '0;
      end
`endif
      out_d[a]   = tc_to_sm(avg[a]);
    end
  end

  // Calibration FSM: raw samples are accumulated, never the corrected ones
  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    clr_hist  = 1'b0;
    for (int a = 0; a < 2; a++) begin
      cal_sum_d[a] = cal_sum_q[a];
      off_d[a]     = off_q[a];
    end
    unique case (state_q)
      StIdle: begin
        if (cal_rise) begin
          state_d   = StCal;
          cal_cnt_d = '0;
          for (int a = 0; a < 2; a++) begin
            cal_sum_d[a] = '0;
          end
        end
      end
      StCal: begin
        if (tick) begin
          if (cal_cnt_q == '1) begin
            state_d   = StIdle;
            cal_cnt_d = '0;
            clr_hist  = 1'b1;
            for (int a = 0; a < 2; a++) begin
              cal_sum_d[a] = '0;
              off_d[a]     = sat11({cal_sh[a][SumW-1], cal_sh[a]});
            end
          end else begin
            cal_cnt_d = cal_cnt_q + AVG_LOG2'(1);
            for (int a = 0; a < 2; a++) begin
              cal_sum_d[a] = cal_tot[a];
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cal_cnt_q <= '0;
      for (int a = 0; a < 2; a++) begin
        cal_sum_q[a] <= '0;
        off_q[a]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      cal_cnt_q <= cal_cnt_d;
      for (int a = 0; a < 2; a++) begin
        cal_sum_q[a] <= cal_sum_d[a];
        off_q[a]     <= off_d[a];
      end
    end
  end

  // Three-stage sample pipeline: capture/correct, average update, output
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ptr_q <= '0;
      for (int a = 0; a < 2; a++) begin
        corr_q[a] <= '0;
        sum_q[a]  <= '0;
        out_q[a]  <= '0;
        for (int i = 0; i < Depth; i++) begin
          hist_q[a][i] <= '0;
        end
      end
    end else begin
      v1_q <= tick && (state_q == StIdle);
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (tick && (state_q == StIdle)) begin
        for (int a = 0; a < 2; a++) begin
          corr_q[a] <= corr_d[a];
        end
      end
      if (clr_hist) begin
        ptr_q <= '0;
        for (int a = 0; a < 2; a++) begin
          sum_q[a] <= '0;
          for (int i = 0; i < Depth; i++) begin
            hist_q[a][i] <= '0;
          end
        end
      end else if (v1_q) begin
        ptr_q <= ptr_q + AVG_LOG2'(1);
        for (int a = 0; a < 2; a++) begin
          hist_q[a][ptr_q] <= corr_q[a];
          sum_q[a]         <= sum_d[a];
        end
      end
      if (v2_q) begin
        for (int a = 0; a < 2; a++) begin
          out_q[a] <= out_d[a];
        end
      end
    end
  end

  assign x_out     = out_q[0];
  assign y_out     = out_q[1];
  assign out_valid = v3_q;
  assign cal_busy  = (state_q == StCal);

endmodule

// File: tb/tb_accel_conditioner.sv
// Directed bench for accel_conditioner with SAMPLE_DIV=4, AVG_LOG2=2, DEADZONE=4.
`timescale 1ns / 1ps

module tb_accel_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] accel_x_in, accel_y_in;
  logic       cal_req;
  logic [8:0] x_out, y_out;
  logic       out_valid, cal_busy;

  int total = 0;
  int bad   = 0;

  accel_conditioner #(
    .SAMPLE_DIV(4),
    .AVG_LOG2  (2),
    .DEADZONE  (8'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .accel_x_in(accel_x_in),
    .accel_y_in(accel_y_in),
    .cal_req   (cal_req),
    .x_out     (x_out),
    .y_out     (y_out),
    .out_valid (out_valid),
    .cal_busy  (cal_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output logic [8:0] xo, output logic [8:0] yo);
    logic seen;
    seen = 1'b0;
    xo   = 'x;
    yo   = 'x;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        xo   = x_out;
        yo   = y_out;
      end
    end
    chk("valid_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_busy(input logic level);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (cal_busy == level) seen = 1'b1;
    end
    chk("busy_level", {31'b0, seen}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [8:0] ramp_x [4] = '{9'h00A, 9'h014, 9'h01E, 9'h028};
  logic [8:0] ramp_y [4] = '{9'h105, 9'h10A, 9'h10F, 9'h114};
  logic [8:0] xo, yo;
  int         n, busy_n, vld_n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cal_req    = 1'b0;
    accel_x_in = 9'h028;
    accel_y_in = 9'h114;
    repeat (3) @(negedge clk);
    chk("rst_x_out", x_out, 9'h000);
    chk("rst_y_out", y_out, 9'h000);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", cal_busy, 0);

    // Latency from reset release: tick after 3 cycles, output 3 cycles later
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("first_valid_lat", n, 6);
    chk("ramp_x0", x_out, ramp_x[0]);
    chk("ramp_y0", y_out, ramp_y[0]);
    for (int k = 1; k < 4; k++) begin
      wait_valid(xo, yo);
      chk("ramp_x", xo, ramp_x[k]);
      chk("ramp_y", yo, ramp_y[k]);
    end

    // Calibrate on x=+40, y=-20
    cal_req = 1'b1;
    @(negedge clk);
    chk("busy_rise", cal_busy, 1);
    cal_req = 1'b0;
    busy_n = 1;
    vld_n  = out_valid ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cal_busy) break;
      busy_n++;
      if (out_valid) vld_n++;
    end
    chk("busy_len", busy_n, 13);
    chk("valid_in_cal", vld_n, 0);
    wait_valid(xo, yo);
    chk("cal_x_first", xo, 9'h000);
    chk("cal_y_first", yo, 9'h000);
    repeat (3) wait_valid(xo, yo);
    chk("cal_x_settle", xo, 9'h000);
    chk("cal_y_settle", yo, 9'h000);

    // Reset mid-calibration drops the offset
    accel_y_in = 9'h000;
    cal_req = 1'b1;
    wait_busy(1'b1);
    cal_req = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midcal_busy", cal_busy, 0);
    chk("midcal_valid", out_valid, 0);
    reset = 1'b0;
    wait_valid(xo, yo);
    chk("midcal_x_first", xo, 9'h00A);
    repeat (3) wait_valid(xo, yo);
    chk("midcal_x_settle", xo, 9'h028);
    chk("midcal_y_settle", yo, 9'h000);

    // Deadzone
    accel_x_in = 9'h003;
    accel_y_in = 9'h104;
    do_reset();
    repeat (4) wait_valid(xo, yo);
`ifdef ACCEL_DEADZONE_EN
    chk("dz_x_small", xo, 9'h000);
    chk("dz_y_small", yo, 9'h000);
`else
    chk("dz_x_small", xo, 9'h003);
    chk("dz_y_small", yo, 9'h104);
`endif
    accel_x_in = 9'h005;
    repeat (4) wait_valid(xo, yo);
    chk("dz_x_pass", xo, 9'h005);

    // Saturation: calibrate y on +200, then feed -255; x carries negative zero
    accel_x_in = 9'h000;
    accel_y_in = 9'h0C8;
    cal_req = 1'b1;
    wait_busy(1'b1);
    cal_req = 1'b0;
    wait_busy(1'b0);
    accel_x_in = 9'h100;
    accel_y_in = 9'h1FF;
    wait_valid(xo, yo);
    chk("sat_y_1", yo, 9'h140);
    chk("negzero_x_1", xo, 9'h000);
    wait_valid(xo, yo);
    chk("sat_y_2", yo, 9'h180);
    repeat (2) wait_valid(xo, yo);
    chk("sat_y_settle", yo, 9'h1FF);
    chk("negzero_x", xo, 9'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_conditioner.md
# accel_conditioner

Conditions the raw sign-magnitude X/Y tilt samples from the accelerometer controller before they reach the threshold ticker and the seven-segment display. Per axis it:
- samples at a fixed rate;
- removes a user-captured zero offset (calibration);
- applies a power-of-two moving average and an optional deadzone;
- re-emits sign-magnitude values with a one-cycle valid strobe.

It sits between the accelerometer controller and the threshold/ticker stage in the top level.

## Interface
Parameters:
- SAMPLE_DIV, 100000 — clk cycles per sample tick (1 kHz at 100 MHz); legal range ≥ 4.
- AVG_LOG2, 3 — log2 of the averaging window (8 samples); legal range 1..5.
- DEADZONE, 8'd4 — magnitude at or below which the output is forced to zero.

Ports:
- clk  in  1  system clock, 100 MHz; sole clock.
- reset  in  1  synchronous, active-high reset.
- accel_x_in  in  9  raw X; [8] sign (1 = negative), [7:0] magnitude.
- accel_y_in  in  9  raw Y; same format.
- cal_req  in  1  debounced calibrate button (level); rising edge requests calibration.
- x_out  out  9  conditioned X, sign-magnitude.
- y_out  out  9  conditioned Y, sign-magnitude.
- out_valid  out  1  one-cycle pulse when x_out/y_out update.
- cal_busy  out  1  high while calibration is collecting samples.

## Operation
- Tick counter runs 0..SAMPLE_DIV-1; tick asserts for one cycle at the terminal count, then the counter wraps to 0.
- On tick, both inputs are captured and converted to 11-bit two's complement.
  - Range is -255..+255.
  - Negative zero (9'h100) converts to 0.
- FSM states: IDLE and CAL.
  - IDLE → CAL on a cal_req rising edge. The edge detector register resets to 0.
  - In CAL, raw (uncorrected) samples are summed over 2^AVG_LOG2 ticks. cal_busy = 1.
  - At the last CAL sample, offset = sum >>> AVG_LOG2 (arithmetic shift).
  - Also at that sample, both averaging buffers and running sums clear to 0, the sample count clears, and the FSM returns to IDLE.
  - cal_req edges during CAL are ignored.
  - No out_valid is issued in CAL; outputs hold their last values.
- IDLE processing per tick:
  - corrected = sample − offset, saturated to [-255, +255].
  - Per axis, a circular buffer of 2^AVG_LOG2 entries feeds a running sum: sum ← sum + new − oldest; the newest entry overwrites the oldest.
  - avg = sum >>> AVG_LOG2, which rounds toward −∞.
  - Deadzone (when compiled in): if |avg| ≤ DEADZONE, the result is 0.
  - The result is converted to sign-magnitude. Zero is always emitted as 9'h000.
- Warm-up: the buffers start at 0, so the output ramps toward the steady value over 2^AVG_LOG2 ticks after reset or after calibration.
- Reset values: x_out = y_out = 9'h000, out_valid = 0, cal_busy = 0; offsets, buffers and sums = 0; FSM = IDLE; tick counter = 0.

## Timing
- Three-stage pipeline per tick T:
  - T+1: capture, convert and offset subtract registered.
  - T+2: buffer write and sum update registered.
  - T+3: shift, deadzone and sign-magnitude output registered; out_valid = 1 in cycle T+3 only.
- Calibration:
  - cal_busy rises the cycle after the cal_req rising edge.
  - It falls the cycle after the 2^AVG_LOG2-th CAL tick. The new offset applies from the next tick.
- A cal_req edge with a sample in flight: the in-flight sample completes and emits out_valid; CAL starts counting at the next tick.
- Reset asserted mid-pipeline or mid-CAL takes effect at the next edge. All state returns to reset values and no out_valid follows.
- Sum width: 11 + AVG_LOG2 bits signed. The sum cannot overflow because entries are saturated to ±255.

## Configuration
- ACCEL_DEADZONE_EN
  - Defined: the deadzone stage is present and DEADZONE is honoured.
  - Undefined: the deadzone logic is absent, DEADZONE is ignored, and avg passes directly to sign-magnitude conversion. Pipeline latency is unchanged (still 3 cycles).

## Test plan
Bench parameters: SAMPLE_DIV = 4, AVG_LOG2 = 2, DEADZONE = 4, ACCEL_DEADZONE_EN defined unless stated.
- Reset, inputs 9'h028 → x_out = y_out = 9'h000, out_valid = 0, cal_busy = 0; first out_valid at cycle 3 after the first tick.
- Hold x = 9'h028 (+40), y = 9'h114 (−20) → four successive valid outputs:
  - x_out: 9'h00A, 9'h014, 9'h01E, 9'h028.
  - y_out: 9'h105, 9'h10A, 9'h10F, 9'h114.
- Hold x = +40, y = −20, pulse cal_req → cal_busy high for 4 ticks with no out_valid, then outputs settle at 9'h000 on both axes.
- Deadzone, after 4 ticks of warm-up:
  - x = 9'h003 → x_out = 9'h000; y = 9'h104 → y_out = 9'h000.
  - x = 9'h005 → x_out = 9'h005.
  - Rerun with ACCEL_DEADZONE_EN undefined → x = 9'h003 gives x_out = 9'h003.
- Saturation and sign rules:
  - Calibrate on y = +200, then apply y = 9'h1FF (−255); the corrected value saturates to −255 and y_out settles at 9'h1FF.
  - Input 9'h100 → output 9'h000.
- Assert reset mid-CAL → cal_busy = 0 next cycle and offset = 0; an uncalibrated x = +40 then ramps to 9'h028.
